// File: rtl/gamecube_bit_receiver.sv
// GameCube single-wire receiver: measures each low pulse on the oversampled
// line, decodes it into a bit, assembles bytes MSB-first, flags errors and frame end.
module gamecube_bit_receiver #(
  parameter int SAMPLES_PER_US = 4,
  parameter int IDLE_US        = 5,
  parameter int LOW_MAX_US     = 5
) (
  input  logic       CLK,
  input  logic       n_RST,
  input  logic       DATALINE,
  output logic       RX_BIT,
  output logic       BIT_VALID,
  output logic [7:0] RX_BYTE,
  output logic       BYTE_VALID,
  output logic       FRAME_END,
  output logic       ERR,
  output logic       BUSY
);

  localparam int T        = SAMPLES_PER_US;
  localparam int LOW_MAX  = LOW_MAX_US * T;
  localparam int IDLE_CYC = IDLE_US * T;
  localparam int GLITCH   = (T / 2 < 1) ? 1 : T / 2;
  localparam int LW       = $clog2(LOW_MAX) + 1;
  localparam int HW       = $clog2(IDLE_CYC) + 1;

  localparam logic [LW-1:0] LOW_LAST   = LW'(LOW_MAX - 1);
  localparam logic [LW-1:0] LOW_SAT    = LW'(LOW_MAX);
  localparam logic [LW-1:0] GLITCH_LIM = LW'(GLITCH);
  localparam logic [LW-1:0] ONE_LIM    = LW'(2 * T);
  localparam logic [HW-1:0] HIGH_LAST  = HW'(IDLE_CYC - 1);
  localparam logic [HW-1:0] HIGH_SAT   = HW'(IDLE_CYC);

  typedef enum logic [1:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, dl_s_q;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic [HW-1:0] high_cnt_q, high_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          bit_seen_q, bit_seen_d;
  logic          rx_bit_q, rx_bit_d;
  logic          bit_valid_q, bit_valid_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_end_q, frame_end_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          new_bit;

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case can infer a latch.
    state_d      = state_q;
    low_cnt_d    = low_cnt_q;
    high_cnt_d   = high_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    bit_seen_d   = bit_seen_q;
    rx_bit_d     = rx_bit_q;
    bit_valid_d  = 1'b0;
    byte_valid_d = 1'b0;
    frame_end_d  = 1'b0;
    err_d        = 1'b0;
    new_bit      = (low_cnt_q < ONE_LIM);

    unique case (state_q)
      ST_WAIT_HIGH: begin
        if (dl_s_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!dl_s_q) begin
          state_d   = ST_LOW;
          low_cnt_d = LW'(1);
        end
      end
      ST_LOW: begin
        if (!dl_s_q) begin
          if (low_cnt_q >= LOW_LAST) begin
            // Stuck low: abandon the frame and wait for the line to recover.
            err_d     = 1'b1;
            bit_idx_d = 3'd0;
            low_cnt_d = LOW_SAT;
            state_d   = ST_WAIT_HIGH;
          end else begin
            low_cnt_d = low_cnt_q + LW'(1);
          end
        end else if (low_cnt_q < GLITCH_LIM) begin
          err_d      = 1'b1;
          bit_idx_d  = 3'd0;
          high_cnt_d = HW'(1);
          state_d    = ST_HIGH;
        end else begin
          bit_valid_d = 1'b1;
          rx_bit_d    = new_bit;
          shift_d     = {shift_q[6:0], new_bit};
          bit_seen_d  = 1'b1;
          high_cnt_d  = HW'(1);
          state_d     = ST_HIGH;
          if (bit_idx_q == 3'd7) begin
            rx_byte_d    = {shift_q[6:0], new_bit};
            byte_valid_d = 1'b1;
            bit_idx_d    = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_HIGH: begin
        if (!dl_s_q) begin
          state_d   = ST_LOW;
          low_cnt_d = LW'(1);
        end else if (high_cnt_q >= HIGH_LAST) begin
          // Line idle long enough: close the frame, dropping any partial byte.
          frame_end_d = bit_seen_q;
          bit_seen_d  = 1'b0;
          bit_idx_d   = 3'd0;
          high_cnt_d  = HIGH_SAT;
          state_d     = ST_IDLE;
        end else begin
          high_cnt_d = high_cnt_q + HW'(1);
        end
      end
      default: state_d = ST_WAIT_HIGH;
    endcase

    busy_d = (state_d == ST_LOW) || (state_d == ST_HIGH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge n_RST) begin
    if (!n_RST) begin
      sync1_q      <= 1'b1;
      dl_s_q       <= 1'b1;
      state_q      <= ST_WAIT_HIGH;
      low_cnt_q    <= '0;
      high_cnt_q   <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      bit_seen_q   <= 1'b0;
      rx_bit_q     <= 1'b0;
      bit_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= DATALINE;
      dl_s_q       <= sync1_q;
      state_q      <= state_d;
      low_cnt_q    <= low_cnt_d;
      high_cnt_q   <= high_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      bit_seen_q   <= bit_seen_d;
      rx_bit_q     <= rx_bit_d;
      bit_valid_q  <= bit_valid_d;
      byte_valid_q <= byte_valid_d;
      frame_end_q  <= frame_end_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign RX_BIT     = rx_bit_q;
  assign BIT_VALID  = bit_valid_q;
  assign RX_BYTE    = rx_byte_q;
  assign BYTE_VALID = byte_valid_q;
  assign FRAME_END  = frame_end_q;
  assign ERR        = err_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_gamecube_bit_receiver.sv
// Directed bench for gamecube_bit_receiver (T=4): bit decode, byte assembly,
// frame end, glitch, stuck-low and mid-byte reset.
module tb_gamecube_bit_receiver;

  logic       CLK = 1'b0;
  logic       n_RST;
  logic       DATALINE;
  logic       RX_BIT, BIT_VALID, BYTE_VALID, FRAME_END, ERR, BUSY;
  logic [7:0] RX_BYTE;

  gamecube_bit_receiver #(
    .SAMPLES_PER_US(4),
    .IDLE_US       (5),
    .LOW_MAX_US    (5)
  ) dut (
    .CLK       (CLK),
    .n_RST     (n_RST),
    .DATALINE  (DATALINE),
    .RX_BIT    (RX_BIT),
    .BIT_VALID (BIT_VALID),
    .RX_BYTE   (RX_BYTE),
    .BYTE_VALID(BYTE_VALID),
    .FRAME_END (FRAME_END),
    .ERR       (ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge away from DUT updates.
  logic       q_bits[$];
  int         q_bit_cyc[$];
  logic [7:0] q_bytes[$];
  int         q_byte_cyc[$];
  int         frame_cnt = 0, frame_cyc = 0, err_cnt = 0, err_cyc = 0, bad_cnt = 0;
  logic       frame_busy = 1'b1;

  always @(negedge CLK) begin
    if (BIT_VALID) begin
      q_bits.push_back(RX_BIT);
      q_bit_cyc.push_back(cyc);
    end
    if (BYTE_VALID) begin
      q_bytes.push_back(RX_BYTE);
      q_byte_cyc.push_back(cyc);
    end
    if (FRAME_END) begin
      frame_cnt++;
      frame_cyc  = cyc;
      frame_busy = BUSY;
    end
    if (ERR) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if ((ERR && (BIT_VALID || FRAME_END)) || (BYTE_VALID && !BIT_VALID)) bad_cnt++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Called on a falling edge; holds the line for n rising edges.
  task automatic hold(input logic v, input int n);
    DATALINE = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      hold(1'b0, 4);
      hold(1'b1, 12);
    end else begin
      hold(1'b0, 12);
      hold(1'b1, 4);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic clear_log();
    q_bits.delete();
    q_bit_cyc.delete();
    q_bytes.delete();
    q_byte_cyc.delete();
  endtask

  function automatic logic [7:0] first_byte();
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8; i++) v = {v[6:0], q_bits[i]};
    return v;
  endfunction

  int t0, r0, f0, e0, s0;

  initial begin
    n_RST    = 1'b0;
    DATALINE = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_rx_byte", {24'h0, RX_BYTE}, 32'h00);
    check("reset_strobes", {27'h0, RX_BIT, BIT_VALID, BYTE_VALID, FRAME_END, ERR}, 32'h0);
    check("reset_busy", {31'h0, BUSY}, 32'h0);
    n_RST = 1'b1;
    hold(1'b1, 6);

    // Single '0' then '1'
    t0 = cyc;
    hold(1'b0, 2);
    check("busy_before_3rd_edge", {31'h0, BUSY}, 32'h0);
    hold(1'b0, 1);
    check("busy_at_3rd_edge", {31'h0, BUSY}, 32'h1);
    hold(1'b0, 9);
    r0 = cyc;
    hold(1'b1, 4);
    send_bit(1'b1);
    hold(1'b1, 30);
    check("two_bits_count", q_bits.size(), 2);
    check("zero_bit_value", {31'h0, q_bits[0]}, 32'h0);
    check("zero_bit_latency", q_bit_cyc[0] - r0, 3);
    check("one_bit_value", {31'h0, q_bits[1]}, 32'h1);
    check("no_err_clean_bits", err_cnt, 0);
    check("frame_end_after_bits", frame_cnt, 1);

    // Byte 0x42 plus stop bit
    clear_log();
    f0 = frame_cnt;
    send_byte(8'h42);
    hold(1'b0, 4);
    hold(1'b1, 30);
    check("byte42_bit_count", q_bits.size(), 9);
    check("byte42_bit_order", {24'h0, first_byte()}, 32'h42);
    check("byte42_stop_bit", {31'h0, q_bits[8]}, 32'h1);
    check("byte42_byte_count", q_bytes.size(), 1);
    check("byte42_value", {24'h0, q_bytes[0]}, 32'h42);
    check("byte42_with_8th_bit", q_byte_cyc[0] - q_bit_cyc[7], 0);
    check("byte42_frame_once", frame_cnt - f0, 1);
    check("byte42_frame_timing", frame_cyc - q_bit_cyc[8], 19);
    check("byte42_busy_at_frame", {31'h0, frame_busy}, 32'h0);
    check("byte42_rx_byte_held", {24'h0, RX_BYTE}, 32'h42);
    check("byte42_busy_idle", {31'h0, BUSY}, 32'h0);

    // Glitch after three good bits, then 0xA5
    clear_log();
    e0 = err_cnt;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    hold(1'b0, 1);
    hold(1'b1, 6);
    send_byte(8'hA5);
    hold(1'b1, 30);
    check("glitch_err_once", err_cnt - e0, 1);
    check("glitch_no_bit", q_bits.size(), 11);
    check("glitch_byte_count", q_bytes.size(), 1);
    check("glitch_byte_a5", {24'h0, q_bytes[0]}, 32'hA5);
    check("glitch_rx_byte", {24'h0, RX_BYTE}, 32'hA5);
    check("strobe_exclusivity", bad_cnt, 0);

    // Stuck low for 40 cycles
    clear_log();
    e0 = err_cnt;
    s0 = cyc;
    hold(1'b0, 40);
    hold(1'b1, 10);
    check("stuck_err_once", err_cnt - e0, 1);
    check("stuck_err_timing", err_cyc - s0, 22);
    check("stuck_no_bit", q_bits.size(), 0);
    send_bit(1'b1);
    hold(1'b1, 30);
    check("after_stuck_bit_count", q_bits.size(), 1);
    check("after_stuck_bit_value", {31'h0, q_bits[0]}, 32'h1);
    check("after_stuck_no_err", err_cnt - e0, 1);

    // Reset during the 5th bit, then 0x3C
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    hold(1'b0, 2);
    n_RST = 1'b0;
    hold(1'b0, 2);
    check("midreset_rx_byte", {24'h0, RX_BYTE}, 32'h00);
    check("midreset_strobes", {27'h0, RX_BIT, BIT_VALID, BYTE_VALID, FRAME_END, ERR}, 32'h0);
    check("midreset_busy", {31'h0, BUSY}, 32'h0);
    hold(1'b1, 2);
    n_RST = 1'b1;
    hold(1'b1, 6);
    clear_log();
    send_byte(8'h3C);
    hold(1'b1, 30);
    check("after_reset_bit_count", q_bits.size(), 8);
    check("after_reset_byte_count", q_bytes.size(), 1);
    check("after_reset_byte_3c", {24'h0, q_bytes[0]}, 32'h3C);
    check("after_reset_rx_byte", {24'h0, RX_BYTE}, 32'h3C);
    check("final_exclusivity", bad_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
